// File: rtl/add_16_pkg.sv
// Shared ALU constants for the adder datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
package add_16_pkg;

    // Native ALU operand width and the carry-lookahead slice width.
    localparam int ALU_WIDTH = 16;
    localparam int ALU_SLICE = 4;

endpackage : add_16_pkg

// File: rtl/add_16_cla4.sv
// 4-bit carry-lookahead adder slice; carries inside the slice are computed
// in parallel from generate/propagate, slices are rippled by the parent.
// Latency: combinational. Backpressure: none.
//
// Ports:
//   a, b : 4-bit operand nibbles
//   cin  : carry into bit 0 of the slice
//   s    : 4-bit sum nibble
//   cout : carry out of bit 3 of the slice
module add_16_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries expanded from c[i+1] = g[i] | p[i] & c[i].
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule : add_16_cla4

// File: rtl/add_16.sv
// Unsigned WIDTH-bit adder with a combinational result and a registered copy.
// Latency: out/ovfl combinational (0 cycles); out_q/ovfl_q one clk cycle.
// Backpressure: none; the registered copy captures every rising clk edge.
//
// Ports:
//   out, ovfl     : combinational sum (mod 2^WIDTH) and unsigned carry-out
//   in1, in2      : unsigned operands
//   clk, rst      : ALU clock, async active-high reset (registered path only)
//   out_q, ovfl_q : out/ovfl registered on rising clk, cleared by rst
module add_16
    import add_16_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    output logic [WIDTH-1:0] out,
    output logic             ovfl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_q,
    output logic             ovfl_q
);

    localparam int NSLICE = WIDTH / ALU_SLICE;

    // carry[k] is the carry into slice k; carry[NSLICE] is the adder carry-out.
    logic [NSLICE:0] carry;

    assign carry[0] = 1'b0;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        add_16_cla4 u_cla4 (
            .a    (in1[k*ALU_SLICE +: ALU_SLICE]),
            .b    (in2[k*ALU_SLICE +: ALU_SLICE]),
            .cin  (carry[k]),
            .s    (out[k*ALU_SLICE +: ALU_SLICE]),
            .cout (carry[k+1])
        );
    end

    assign ovfl = carry[NSLICE];

    // Registered copy; reset only touches these flops, never the combinational path.
    logic [WIDTH-1:0] out_d;
    logic             ovfl_d;

    assign out_d  = out;
    assign ovfl_d = ovfl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            ovfl_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            ovfl_q <= ovfl_d;
        end
    end

endmodule : add_16

// File: tb/tb_add_16.sv
// Self-checking bench for add_16: directed corner vectors, random vectors
// against an integer-arithmetic model, and the registered/reset path.
module tb_add_16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in1, in2, out, out_q;
    logic        ovfl, ovfl_q;

    int n_checks = 0;
    int n_fail   = 0;

    add_16 dut (
        .out    (out),
        .ovfl   (ovfl),
        .in1    (in1),
        .in2    (in2),
        .clk    (clk),
        .rst    (rst),
        .out_q  (out_q),
        .ovfl_q (ovfl_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition, 17-bit result {carry, sum}.
    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
        return 17'(s);
    endfunction

    // Directed vectors: operand A, operand B, expected {ovfl, out}.
    localparam int NDIR = 15;
    logic [15:0] dir_a   [NDIR] = '{16'h0001, 16'h0003, 16'h000F, 16'h000F, 16'h00FF,
                                    16'h00F0, 16'hAAAA, 16'h0F0F, 16'h8000, 16'hFFFF,
                                    16'h8000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001};
    logic [15:0] dir_b   [NDIR] = '{16'h0001, 16'h0005, 16'h000F, 16'h0001, 16'h0001,
                                    16'h000F, 16'h5555, 16'hF0F0, 16'h7FFF, 16'h0001,
                                    16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    logic [16:0] dir_exp [NDIR] = '{17'h00002, 17'h00008, 17'h0001E, 17'h00010, 17'h00100,
                                    17'h000FF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h10000,
                                    17'h10000, 17'h1FFFE, 17'h10000, 17'h00000, 17'h00001};

    initial begin
        logic [16:0] exp_reg;

        rst = 1'b1;
        in1 = 16'h0000;
        in2 = 16'h0000;
        #1;
        check("reset_out_q",  32'(out_q),  32'h0);
        check("reset_ovfl_q", 32'(ovfl_q), 32'h0);

        @(negedge clk);
        rst = 1'b0;

        // Directed combinational vectors, plus their registered copy.
        for (int i = 0; i < NDIR; i++) begin
            @(negedge clk);
            in1 = dir_a[i];
            in2 = dir_b[i];
            #1;
            check($sformatf("dir%0d_comb", i), 32'({ovfl, out}), 32'(dir_exp[i]));
            @(posedge clk);
            #1;
            check($sformatf("dir%0d_reg", i), 32'({ovfl_q, out_q}), 32'(dir_exp[i]));
        end

        // Random vectors against the integer model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in1 = 16'($urandom);
            in2 = 16'($urandom);
            exp_reg = ref_sum(in1, in2);
            #1;
            check($sformatf("rnd%0d_comb", i), 32'({ovfl, out}), 32'(exp_reg));
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_reg", i), 32'({ovfl_q, out_q}), 32'(exp_reg));
        end

        // Mid-run reset: registered path clears at once, combinational stays valid.
        @(negedge clk);
        in1 = 16'hFFFF;
        in2 = 16'h0001;
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_reg",  32'({ovfl_q, out_q}), 32'h0);
        check("rst_comb_valid", 32'({ovfl, out}),     32'h10000);
        @(posedge clk);
        #1;
        check("rst_hold_reg", 32'({ovfl_q, out_q}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_noclk", 32'({ovfl_q, out_q}), 32'h0);
        @(posedge clk);
        #1;
        check("rst_first_capture", 32'({ovfl_q, out_q}), 32'h10000);

        // One-edge latency on an input change.
        @(negedge clk);
        in1 = 16'h0003;
        in2 = 16'h0005;
        #1;
        check("lat_comb",       32'({ovfl, out}),     32'h00008);
        check("lat_reg_before", 32'({ovfl_q, out_q}), 32'h10000);
        @(posedge clk);
        #1;
        check("lat_reg_after", 32'({ovfl_q, out_q}), 32'h00008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_add_16

// File: doc/add_16.md
Name: add_16

Overview:
- 16-bit unsigned binary adder used by the ALU datapath.
- Primary result is combinational: `out` = low 16 bits of `in1`+`in2`, `ovfl` = carry-out of bit 15.
- A registered copy of the result (`out_q`/`ovfl_q`) serves clocked consumers. It uses the single ALU clock and an asynchronous active-high reset.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4; only 16 is verified.

Ports:
- clk  input  1  ALU clock; registered outputs update on rising edge.
- rst  input  1  asynchronous, active-high reset; clears registered outputs only.
- out  output  WIDTH  combinational sum, (in1 + in2) mod 2^WIDTH.
- ovfl  output  1  combinational carry-out of MSB (unsigned overflow).
- in1  input  WIDTH  operand A, unsigned.
- in2  input  WIDTH  operand B, unsigned.
- out_q  output  WIDTH  `out` registered on rising clk.
- ovfl_q  output  1  `ovfl` registered on rising clk.

Behaviour:
- Positional instantiation order of the original four ports is fixed: out, ovfl, in1, in2. New ports (clk, rst, out_q, ovfl_q) connect by name.
- `out`/`ovfl` are purely combinational with zero-cycle latency. They must settle within one simulation time unit of any input change. They are independent of `clk` and `rst`, and valid even while `rst` is high.
- Arithmetic: the 17-bit result {ovfl, out} = in1 + in2, zero-extended. There is no carry-in.
- `ovfl` is the unsigned carry, not signed two's-complement overflow:
  - 0x0001+0xFFFF gives ovfl=1.
  - 0x8000+0x7FFF gives ovfl=0.
- Wrap-around: results ≥ 2^16 wrap modulo 2^16 with ovfl=1.
- Maximum case: 0xFFFF+0xFFFF = 0xFFFE with ovfl=1.
- No X propagation from the registered path into the combinational path. Combinational outputs are X only if inputs are X/Z.
- Registered path:
  - On each rising clk, out_q<=out and ovfl_q<=ovfl, giving one-cycle latency.
  - rst asserted forces out_q=0 and ovfl_q=0 immediately, with no clock required.
  - rst deasserted: capture resumes at the next rising edge.
  - If rst is released coincident with a clock edge, the registers stay 0 for that edge.
- Structure: the carry chain is built from WIDTH/4 4-bit carry-lookahead slices, rippled slice-to-slice.
  - Slice 0 carry-in = 0.
  - ovfl = carry-out of the top slice.
  - Each slice computes per-bit generate g=a&b and propagate p=a^b, four lookahead carries, sum bits s=p^c, and a slice carry-out.

Decomposition:
- Shared ALU package: constant ALU_WIDTH=16. Nibble slice width 4 as constant ALU_SLICE.
- One natural sub-module: add_16_cla4 (4-bit CLA slice).
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - Instantiated by a generate loop WIDTH/4 times.
- Output registers live in add_16 itself.

Test Plan:
- Small sums: 0x0001+0x0001 -> out=0x0002, ovfl=0; 0x0003+0x0005 -> 0x0008, 0; 0x000F+0x000F -> 0x001E, 0.
- Carry propagation across slices:
  - 0x000F+0x0001 -> 0x0010, 0.
  - 0x00FF+0x0001 -> 0x0100, 0.
  - 0x00F0+0x000F -> 0x00FF, 0 (no carry).
- Complementary patterns:
  - 0xAAAA+0x5555 -> 0xFFFF, 0.
  - 0x0F0F+0xF0F0 -> 0xFFFF, 0.
  - 0x8000+0x7FFF -> 0xFFFF, 0.
- Overflow/wrap:
  - 0xFFFF+0x0001 -> 0x0000, 1.
  - 0x8000+0x8000 -> 0x0000, 1.
  - 0xFFFF+0xFFFF -> 0xFFFE, 1.
  - 0x0001+0xFFFF -> 0x0000, 1.
- Identity: 0x0000+0x0000 -> 0x0000, 0; 0x0001+0x0000 -> 0x0001, 0.
- Registered path:
  - Apply rst mid-run with in1=0xFFFF, in2=0x0001. Expect out_q=0 and ovfl_q=0 immediately, while out=0x0000 and ovfl=1 stay combinationally valid.
  - Release rst; after the first rising clk expect out_q=0x0000, ovfl_q=1.
  - Change inputs to 0x0003/0x0005; out_q becomes 0x0008 exactly one edge later.
